// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the popcount accumulator.
// Holds the FSM state encoding and the ones-counter width function.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_e;

  // Bits needed to hold a count from 0 to width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcount_core.sv
// Combinational ones counter for one WIDTH-bit sample.
module popcount_core
  import popcount_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            data_i,
  output logic [cnt_width(WIDTH)-1:0] ones_o
);

  localparam int CW = cnt_width(WIDTH);

  // Sum the sample bits one at a time.
  always_comb begin
    ones_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_o = ones_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Two-stage popcount pipeline with saturating running total and hit counter.
// S1 holds the raw sample; S2 holds the counts, totals and the SAT/ACCUM FSM.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ACC_W  = 8,
  parameter int THRESH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(WIDTH)-1:0] out_ones,
  output logic [cnt_width(WIDTH)-1:0] out_zeros,
  output logic [ACC_W-1:0]            out_total,
  output logic [ACC_W-1:0]            out_hits,
  output logic                        out_sat
);

  localparam int CW    = cnt_width(WIDTH);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [CW-1:0]    zeros_q, zeros_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [ACC_W-1:0] hits_q, hits_d;
  state_e           state_q, state_d;

  logic             s1_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             s2_load_s;
  logic             sum_sat_s;
  logic             hit_s;
  logic             out_sat_s;
  logic [CW-1:0]    ones_s;
  logic [SUM_W-1:0] sum_s;

  popcount_core #(.WIDTH(WIDTH)) u_core (
    .data_i (s1_data_q),
    .ones_o (ones_s)
  );

  // Handshake: S1 drains into S2 whenever S2 is empty or being consumed.
  always_comb begin
    s1_adv_s   = !out_valid_q || out_ready;
    in_ready_s = !rst && !clr && (!s1_valid_q || s1_adv_s);
    accept_s   = in_valid && in_ready_s;
    s2_load_s  = s1_adv_s && s1_valid_q;
  end

  // The sum is formed one bit wider so overflow is seen before clamping.
  always_comb begin
    sum_s     = {1'b0, total_q} + SUM_W'(ones_s);
    sum_sat_s = (sum_s >= {1'b0, ACC_MAX});
    hit_s     = (int'(ones_s) >= THRESH);
  end

  // Next-state for both pipeline stages; clr empties them and zeroes totals.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    ones_d      = ones_q;
    zeros_d     = zeros_q;
    total_d     = total_q;
    hits_d      = hits_q;
    if (clr) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      ones_d      = '0;
      zeros_d     = '0;
      total_d     = '0;
      hits_d      = '0;
    end else begin
      if (accept_s) begin
        s1_valid_d = 1'b1;
        s1_data_d  = in_data;
      end else if (s1_adv_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (s1_adv_s) begin
        out_valid_d = s1_valid_q;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (s2_load_s) begin
        ones_d  = ones_s;
        zeros_d = CW'(WIDTH) - ones_s;
        total_d = sum_sat_s ? ACC_MAX : sum_s[ACC_W-1:0];
        hits_d  = (hit_s && (hits_q != ACC_MAX)) ? hits_q + ACC_W'(1) : hits_q;
      end else begin
        ones_d = ones_q;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      ones_q      <= '0;
      zeros_q     <= '0;
      total_q     <= '0;
      hits_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      ones_q      <= ones_d;
      zeros_q     <= zeros_d;
      total_q     <= total_d;
      hits_q      <= hits_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a sample that already saturates the total skips ACCUM.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (s2_load_s) begin
      case (state_q)
        IDLE:    state_d = sum_sat_s ? SAT : ACCUM;
        ACCUM:   state_d = sum_sat_s ? SAT : ACCUM;
        SAT:     state_d = SAT;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM output decode.
  always_comb begin
    out_sat_s = (state_q == SAT);
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_ones  = ones_q;
  assign out_zeros = zeros_q;
  assign out_total = total_q;
  assign out_hits  = hits_q;
  assign out_sat   = out_sat_s;

endmodule

// File: tb/tb_popcount_accum.sv
// Randomised and directed bench for popcount_accum against a queue-based model.
// Two instances (ACC_W=8 and ACC_W=4) share one stimulus stream.
module tb_popcount_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_sat;
  logic [2:0] out_ones, out_zeros;
  logic [7:0] out_total, out_hits;
  logic       in_ready4, out_valid4, out_sat4;
  logic [2:0] out_ones4, out_zeros4;
  logic [3:0] out_total4, out_hits4;

  popcount_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ones(out_ones), .out_zeros(out_zeros), .out_total(out_total),
    .out_hits(out_hits), .out_sat(out_sat)
  );

  popcount_accum #(.WIDTH(4), .ACC_W(4), .THRESH(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ones(out_ones4), .out_zeros(out_zeros4), .out_total(out_total4),
    .out_hits(out_hits4), .out_sat(out_sat4)
  );

  typedef struct {
    int ones;
    int tot;
    int hits;
    int tot4;
    int hits4;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   dlv_ones[$];
  int   m_tot, m_hits, m_tot4, m_hits4;
  int   cyc = 0;
  bit   strict = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic       obs_in_ready, obs_valid, obs_sat, obs_acc, obs_dlv, obs4_sat;
  logic [2:0] obs_ones, obs_zeros;
  logic [7:0] obs_total, obs_hits;
  logic [3:0] obs4_total;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ones_of(input logic [3:0] d);
    int n = 0;
    for (int i = 0; i < 4; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic int sat_add(input int a, input int b, input int lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

  // One clock cycle: drive, observe against the model, update the model, advance.
  task automatic step(input bit iv, input logic [3:0] d, input bit orr, input bit c, input bit r);
    exp_t e;
    bit   exp_v;
    in_valid = iv; in_data = d; out_ready = orr; clr = c; rst = r;
    #1;
    obs_in_ready = in_ready; obs_valid = out_valid; obs_ones = out_ones;
    obs_zeros = out_zeros; obs_total = out_total; obs_hits = out_hits;
    obs_sat = out_sat; obs4_total = out_total4; obs4_sat = out_sat4;
    obs_acc = iv && in_ready;
    obs_dlv = out_valid && orr;
    if (r || c) check_val("in_ready_low", 64'(in_ready), 64'(0));
    if (strict) begin
      exp_v = (q.size() > 0) && (q[0].cyc + 2 == cyc);
      check_val("latency", 64'(out_valid), 64'(exp_v));
    end
    if (q.size() == 0) begin
      check_val("valid_idle", 64'(out_valid), 64'(0));
      check_val("valid4_idle", 64'(out_valid4), 64'(0));
    end else if (out_valid) begin
      e = q[0];
      check_val("ones", 64'(out_ones), 64'(e.ones));
      check_val("zeros", 64'(out_zeros), 64'(4 - e.ones));
      check_val("total", 64'(out_total), 64'(e.tot));
      check_val("hits", 64'(out_hits), 64'(e.hits));
      check_val("sat", 64'(out_sat), 64'(e.tot == 255));
      check_val("valid4", 64'(out_valid4), 64'(1));
      check_val("ones4", 64'(out_ones4), 64'(e.ones));
      check_val("zeros4", 64'(out_zeros4), 64'(4 - e.ones));
      check_val("total4", 64'(out_total4), 64'(e.tot4));
      check_val("hits4", 64'(out_hits4), 64'(e.hits4));
      check_val("sat4", 64'(out_sat4), 64'(e.tot4 == 15));
    end
    if (r || c) begin
      q.delete();
      m_tot = 0; m_hits = 0; m_tot4 = 0; m_hits4 = 0;
    end else begin
      if (obs_dlv) begin
        dlv_ones.push_back(int'(out_ones));
        if (q.size() > 0) void'(q.pop_front());
      end
      if (obs_acc) begin
        e.ones  = ones_of(d);
        m_tot   = sat_add(m_tot, e.ones, 255);
        m_tot4  = sat_add(m_tot4, e.ones, 15);
        m_hits  = sat_add(m_hits, (e.ones >= 4) ? 1 : 0, 255);
        m_hits4 = sat_add(m_hits4, (e.ones >= 4) ? 1 : 0, 15);
        e.tot = m_tot; e.hits = m_hits; e.tot4 = m_tot4; e.hits4 = m_hits4;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [3:0] smp [3];
  int         tot3 [5];
  int         k;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    m_tot = 0; m_hits = 0; m_tot4 = 0; m_hits4 = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    strict = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("rst_valid", 64'(obs_valid), 64'(0));
    check_val("rst_ones", 64'(obs_ones), 64'(0));
    check_val("rst_zeros", 64'(obs_zeros), 64'(0));
    check_val("rst_total", 64'(obs_total), 64'(0));
    check_val("rst_hits", 64'(obs_hits), 64'(0));
    check_val("rst_sat", 64'(obs_sat), 64'(0));
    check_val("rst_ready", 64'(obs_in_ready), 64'(1));

    // Scenario 1: three samples, two-cycle latency.
    step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    check_val("s1_lat_a", 64'(obs_valid), 64'(0));
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    check_val("s1_lat_b", 64'(obs_valid), 64'(0));
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    check_val("s1_r0_valid", 64'(obs_valid), 64'(1));
    check_val("s1_r0", 64'({obs_ones, obs_zeros, obs_total}), 64'({3'd1, 3'd3, 8'd1}));
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s1_r1", 64'({obs_ones, obs_zeros, obs_total}), 64'({3'd4, 3'd0, 8'd5}));
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s1_r2", 64'({obs_ones, obs_zeros, obs_total}), 64'({3'd0, 3'd4, 8'd5}));
    check_val("s1_hits", 64'(obs_hits), 64'(1));
    strict = 1'b0;

    // Scenario 2: backpressure for five cycles while streaming three samples.
    smp[0] = 4'b0001; smp[1] = 4'b0011; smp[2] = 4'b0111;
    dlv_ones.delete();
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(k < 3, smp[(k < 3) ? k : 0], i >= 5, 1'b0, 1'b0);
      if (obs_acc) k++;
      if (i == 2) check_val("s2_ready_drop", 64'(obs_in_ready), 64'(0));
      if (i == 4) check_val("s2_accepted", 64'(k), 64'(2));
    end
    check_val("s2_count", 64'(dlv_ones.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < dlv_ones.size()) check_val("s2_order", 64'(dlv_ones[i]), 64'(i + 1));
    end

    // Scenario 3: saturation of the narrow accumulator.
    tot3[0] = 4; tot3[1] = 8; tot3[2] = 12; tot3[3] = 15; tot3[4] = 15;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(i < 5, 4'b1111, 1'b1, 1'b0, 1'b0);
      if (i >= 2) begin
        check_val("s3_total4", 64'(obs4_total), 64'(tot3[i - 2]));
        check_val("s3_sat4", 64'(obs4_sat), 64'(i >= 5));
      end
    end

    // Scenario 4: clr with two samples in flight.
    step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0111, 1'b0, 1'b1, 1'b0);
    check_val("s4_clr_ready", 64'(obs_in_ready), 64'(0));
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s4_dropped_a", 64'(obs_valid), 64'(0));
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s4_dropped_b", 64'(obs_valid), 64'(0));
    step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s4_valid", 64'(obs_valid), 64'(1));
    check_val("s4_total", 64'(obs_total), 64'(2));
    check_val("s4_hits", 64'(obs_hits), 64'(0));
    check_val("s4_sat", 64'(obs_sat), 64'(0));

    // Scenario 5: one-cycle rst mid-stream.
    step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s5_zero", 64'({obs_valid, obs_ones, obs_zeros, obs_total, obs_hits, obs_sat}), 64'(0));
    check_val("s5_ready", 64'(obs_in_ready), 64'(1));
    step(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_val("s5_first_total", 64'(obs_total), 64'(2));

    // Random phase A: no backpressure, exact latency and full throughput.
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    strict = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'b1, 1'b0, 1'b0);
      check_val("ra_ready", 64'(obs_in_ready), 64'(1));
    end
    strict = 1'b0;

    // Random phase B: backpressure with occasional clr and rst.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
    end

    // Random phase C: long run without clear to drive the wide total to saturation.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 7) != 0, 4'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    end
    check_val("rc_saturated", 64'(m_tot), 64'(255));

    for (int i = 0; i < 20; i++) begin
      if (q.size() > 0) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    check_val("drain", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the input sample width in bits.
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the running-total width in bits.
REQ-003 The block SHALL have parameter THRESH, default 4, giving the per-sample ones count at or above which a sample is counted as a hit.
REQ-004 Ports SHALL be, in order:
  clk  in  1  single clock; all state updates on posedge clk
  rst  in  1  synchronous, active-high reset
  clr  in  1  synchronous clear of the accumulator, hit counter and FSM
  in_valid  in  1  in_data is valid
  in_ready  out  1  block can accept a sample this cycle
  in_data  in  WIDTH  sample to be counted
  out_valid  out  1  result fields are valid
  out_ready  in  1  downstream accepts the result
  out_ones  out  $clog2(WIDTH+1)  count of 1 bits in the sample
  out_zeros  out  $clog2(WIDTH+1)  count of 0 bits in the sample (WIDTH - out_ones)
  out_total  out  ACC_W  running sum of out_ones since reset or clr, saturating
  out_hits  out  ACC_W  number of samples with ones >= THRESH, saturating
  out_sat  out  1  out_total has saturated (sticky)

Function
REQ-005 A sample SHALL be accepted on a cycle where in_valid && in_ready; a result SHALL be delivered on a cycle where out_valid && out_ready.
REQ-006 The block SHALL be a 2-stage pipeline: S1 registers in_data; S2 registers the counts and the updated totals.
REQ-007 Without backpressure, out_valid SHALL rise 2 cycles after acceptance, and the block SHALL sustain 1 sample per cycle.
REQ-008 in_ready SHALL be high when S1 is empty, or when S1 advances this cycle.
REQ-009 S1 SHALL advance when S2 is empty or out_ready is high.
REQ-010 While out_valid && !out_ready, all output fields SHALL hold stable; no sample SHALL be dropped or duplicated.
REQ-011 out_ones SHALL equal the number of 1 bits in the sample; out_zeros SHALL equal WIDTH minus out_ones.
REQ-012 out_total SHALL be the sum including the current sample, computed at ACC_W+1 bits and clamped to 2^ACC_W-1.
REQ-013 out_hits SHALL increment by 1, saturating at 2^ACC_W-1, when out_ones >= THRESH.
REQ-014 The FSM SHALL have states IDLE, ACCUM and SAT.
  IDLE -> ACCUM on the first sample entering S2.
  ACCUM -> SAT when the computed sum is >= 2^ACC_W-1.
  SAT holds until rst or clr.
  out_sat SHALL be 1 only in SAT.
REQ-015 In SAT, out_total SHALL stay at 2^ACC_W-1; counts and hits SHALL still update.
REQ-016 clr SHALL take effect on the cycle it is high: totals and hits zeroed, FSM to IDLE, pipeline stages emptied, in_ready low that cycle.
REQ-017 If clr and in_valid are high together, the sample SHALL NOT be accepted.
REQ-018 clr with out_valid high SHALL drop the pending result; out_valid SHALL be 0 on the next cycle.
REQ-019 WIDTH=1 SHALL be legal; for WIDTH=1, out_ones and out_zeros SHALL be 1 bit wide.

Reset
REQ-020 On rst high at posedge clk, the following SHALL reset to 0: out_valid, out_ones, out_zeros, out_total, out_hits, out_sat and both stage valid flags.
REQ-021 On rst, the FSM SHALL go to IDLE.
REQ-022 While rst is high, in_ready SHALL be 0.
REQ-023 rst SHALL take priority over clr.
REQ-024 rst asserted mid-stream SHALL discard all in-flight samples; the first result after release SHALL reflect only post-reset samples.

Structure
REQ-025 Package popcount_pkg SHALL hold the FSM state enum (IDLE, ACCUM, SAT) and a cnt_width(WIDTH) constant function.
REQ-026 Sub-module popcount_core SHALL be the single natural sub-module: combinational WIDTH-bit ones counter, instantiated in S2.

Verification
REQ-027 Scenario 1: with WIDTH=4 and out_ready=1, send 4'b0001, then 4'b1111, then 4'b0000. Required results: ones/zeros/total = 1/3/1, 4/0/5, 0/4/5; out_hits ends at 1; each result arrives 2 cycles after its input.
REQ-028 Scenario 2: hold out_ready=0 for 5 cycles while streaming 3 samples. Required: in_ready drops after 2 samples are accepted; outputs hold stable; all 3 results appear in order after out_ready returns to 1.
REQ-029 Scenario 3: with ACC_W=4, send 4'b1111 five times. Required: out_total is 4, 8, 12, 15, 15; out_sat rises on the 4th result and stays 1.
REQ-030 Scenario 4: assert clr with 2 samples in flight. Required: no results emerge; the next sample 4'b0011 gives total=2, hits=0 and FSM state ACCUM.
REQ-031 Scenario 5: assert rst for 1 cycle mid-stream. Required: all outputs are 0 the cycle after; in_ready returns to 1 the cycle after rst falls.
